pipe_csa_addsub: RTL and testbench

Parametrised, pipelined carry-select adder/subtractor with a valid/ready stream interface. It is the successor to the fixed 32-bit combinational carry-select adder. Each pipeline stage resolves one SEG-bit segment, computing both carry-in candidates and selecting with the registered carry from the stage below. It feeds the ALU execute path, where long add/sub chains must not limit clock frequency.

---
 rtl/pipe_csa_addsub.sv | 141 ++++++++++++++
 tb/tb_pipe_csa_addsub.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pipe_csa_addsub.sv
// pipe_csa_addsub: pipelined carry-select adder/subtractor with a valid/ready
// stream interface. Each of the L = WIDTH/SEG stages resolves one SEG-bit
// segment. It computes both carry-in candidates and picks one with the carry
// registered by the stage below.
// Optional feature: define PIPE_CSA_SATURATE_EN to clamp the sum on signed
// overflow. Without it, the sum is the modulo-2^WIDTH result.
module pipe_csa_addsub #(
  parameter int WIDTH = 32,  // multiple of SEG, at least 2*SEG
  parameter int SEG   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  // Pipeline depth equals the latency in cycles.
  localparam int L = WIDTH / SEG;

  // Effective operands: subtraction is a + ~b + 1, and c_in is ignored.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | c_in;

  // One global advance enable: all stages shift together or all hold.
  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Per-stage state.
  // word_q holds the finished segment sums in its upper bits and the
  // not-yet-consumed bits of A in its lower bits. Each stage rotates one
  // segment of A out and its segment sum in. After the last stage, the word
  // is the complete result.
  // bop_q carries the unconsumed B' bits, shifted down so that each stage
  // always reads its own segment from bits [SEG-1:0].
  logic [L-1:0]     vld_q;
  logic [WIDTH-1:0] word_q [L];
  logic [WIDTH-1:0] word_d [L];
  logic             cry_q  [L];
  logic             cry_d  [L];
  logic [WIDTH-1:0] bop_q  [L-1];
  logic [WIDTH-1:0] bop_d  [L-1];
  logic             ovf_q;
  logic             ovf_d;

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic [WIDTH-1:0] src_w;
    logic [SEG-1:0]   b_seg;
    logic             src_c;
    logic [SEG:0]     seg_c0;
    logic [SEG:0]     seg_c1;
    logic [SEG:0]     seg_sel;

    if (k == 0) begin : g_first
      assign src_w    = a;
      assign b_seg    = b_eff[SEG-1:0];
      assign src_c    = cin_eff;
      assign bop_d[0] = {{SEG{1'b0}}, b_eff[WIDTH-1:SEG]};
    end else begin : g_next
      assign src_w = word_q[k-1];
      assign b_seg = bop_q[k-1][SEG-1:0];
      assign src_c = cry_q[k-1];
      if (k < L-1) begin : g_fwd_b
        assign bop_d[k] = {{SEG{1'b0}}, bop_q[k-1][WIDTH-1:SEG]};
      end
    end

    // Both carry candidates are resolved in parallel. The registered carry
    // from below only drives the final 2:1 select, so the per-cycle carry
    // path is SEG bits plus one mux.
    assign seg_c0  = {1'b0, src_w[SEG-1:0]} + {1'b0, b_seg};
    assign seg_c1  = {1'b0, src_w[SEG-1:0]} + {1'b0, b_seg} + {{SEG{1'b0}}, 1'b1};
    assign seg_sel = src_c ? seg_c1 : seg_c0;
    assign cry_d[k] = seg_sel[SEG];

    if (k < L-1) begin : g_mid
      assign word_d[k] = {seg_sel[SEG-1:0], src_w[WIDTH-1:SEG]};
    end else begin : g_last
      logic [WIDTH-1:0] raw_sum;
      logic             c_msb;
      assign raw_sum = {seg_sel[SEG-1:0], src_w[WIDTH-1:SEG]};
      // Carry into the MSB, recovered from the MSB operand bits and the MSB sum bit.
      assign c_msb = src_w[SEG-1] ^ b_seg[SEG-1] ^ seg_sel[SEG-1];
      assign ovf_d = c_msb ^ seg_sel[SEG];
`ifdef PIPE_CSA_SATURATE_EN
      // Overflow means both operands had the same sign, so A's MSB (still in
      // src_w here) selects the clamp direction.
      assign word_d[k] = !ovf_d       ? raw_sum :
                         src_w[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                        {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign word_d[k] = raw_sum;
`endif
    end
  end

  // Pipeline registers: all shift on adv, all hold otherwise.
  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of the stage below.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: data registers are reset too (not just valid bits) so the outputs read zero out of reset.
      vld_q <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < L; k++) begin
        word_q[k] <= '0;
        cry_q[k]  <= 1'b0;
      end
      for (int k = 0; k < L-1; k++) begin
        bop_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q <= {vld_q[L-2:0], in_valid};
      ovf_q <= ovf_d;
      for (int k = 0; k < L; k++) begin
        word_q[k] <= word_d[k];
        cry_q[k]  <= cry_d[k];
      end
      for (int k = 0; k < L-1; k++) begin
        bop_q[k] <= bop_d[k];
      end
    end
  end

  // Outputs come straight from the last-stage registers.
  assign out_valid = vld_q[L-1];
  assign sum       = word_q[L-1];
  assign c_out     = cry_q[L-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_csa_addsub.sv
// tb_pipe_csa_addsub: directed self-checking bench for pipe_csa_addsub
// (WIDTH=32, SEG=8, latency 4). The expectations follow
// PIPE_CSA_SATURATE_EN when the bench is built with it.
module tb_pipe_csa_addsub;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_assert = 0;
  int n_fail   = 0;

  pipe_csa_addsub #(.WIDTH(W), .SEG(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Sends one beat, checks the 4-cycle latency and the result, and lets it
  // retire. It is entered and left 1 time unit after a rising edge.
  task automatic run_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tcin, input logic tsub,
                         input logic [W-1:0] es, input logic ec, input logic eo);
    a = ta; b = tb; c_in = tcin; sub = tsub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;                   // accepted at edge n
    in_valid = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    check({tag, "_early"}, out_valid, 1'b0); // after edge n+2
    @(posedge clock); #1;                   // after edge n+3
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, c_out, ec);
    check({tag, "_ovf"}, ovf, eo);
    @(posedge clock); #1;                   // retired, bubble behind it
    check({tag, "_gone"}, out_valid, 1'b0);
  endtask

  logic [W-1:0] exp_ovf_add;
  logic [W-1:0] exp_ovf_sub;
  int  sent;
  int  got;
  int  last_cyc;
  logic acc;

  initial begin
`ifdef PIPE_CSA_SATURATE_EN
    exp_ovf_add = 32'h7FFF_FFFF;
    exp_ovf_sub = 32'h8000_0000;
`else
    exp_ovf_add = 32'h8000_0000;
    exp_ovf_sub = 32'h7FFF_FFFF;
`endif
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 32'h0);
    check("rst_cout", c_out, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clock); #1;
    reset = 1'b0;

    // Single beats: function, overflow, carry across segment boundaries.
    run_one("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, exp_ovf_add,   1'b0, 1'b1);
    run_one("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0);
    run_one("cin_seg",  32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    run_one("cin_all",  32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
    run_one("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, exp_ovf_sub,   1'b1, 1'b1);
    run_one("sub_cin",  32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);

    // 8 back-to-back beats; out_ready low in cycles 4..6 (the first result
    // shows in cycle 4). Beat i: a = 0x10000000 + i, b = 3*i.
    sent = 0; got = 0; last_cyc = -1;
    c_in = 1'b0; sub = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (sent < 8);
      a = 32'h1000_0000 + 32'(sent);
      b = 32'(sent * 3);
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
        check("stall_hold", sum, 32'h1000_0000);
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check("stream_sum", sum, 32'h1000_0000 + 32'(got * 4));
        got++;
        if (got == 8) last_cyc = cyc;
      end
      @(posedge clock); #1;
      if (acc) sent++;
      if (got == 8) break;
    end
    in_valid = 1'b0;
    check("stream_count", 32'(got), 32'd8);
    check("stream_cycles", 32'(last_cyc), 32'd14);

    // Reset with the first beat at the output and two more in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 32'h100 * 32'(i + 1);
      b = 32'h1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(posedge clock); #1;
    check("pre_rst_valid", out_valid, 1'b1);
    check("pre_rst_sum", sum, 32'h0000_0101);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_sum", sum, 32'h0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    @(posedge clock); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      check("post_rst_quiet", out_valid, 1'b0);
    end
    run_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
